// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle, with a sign fix-up cycle and a registered HI/LO result pair.
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             mult_div_done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1) as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x,
                                           input logic sgn);
    return (sgn && (x < 0)) ? neg_w(x) : x;
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dbz_q, dbz_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [WIDTH-1:0]       a_raw_q, a_raw_d;
  logic                   negq_q, negq_d;
  logic                   negr_q, negr_d;
  logic                   zero_q, zero_d;
  logic                   is_div_q, is_div_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH+1:0]       div_trial;

  assign a_mag = mag(op_a, signed_op);
  assign b_mag = mag(op_b, signed_op);

  // Multiply: upper half accumulates, multiplier bits shift out of the lower half.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: dividend bits shift out of acc low half, quotient bits shift in.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    zero_d   = zero_q;
    is_div_d = is_div_q;

    case (state_q)
      S_IDLE: begin
        if (mult_start || div_start) begin
          is_div_d = !mult_start;
          negq_d   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          negr_d   = signed_op & op_a[WIDTH-1];
          zero_d   = (op_b == '0);
          a_raw_d  = op_a;
          rem_d    = '0;
          dbz_d    = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (mult_start) begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            opnd_d  = a_mag;
            state_d = S_MUL;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = b_mag;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
        rem_d = div_trial[WIDTH+1] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          acc_d = negq_q ? neg_2w(acc_q) : acc_q;
        end else if (zero_q) begin
          acc_d = {a_raw_q, {WIDTH{1'b1}}};
        end else begin
          acc_d = {(negr_q ? neg_w(rem_q) : rem_q),
                   (negq_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0])};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dbz_d   = is_div_q & zero_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded on acceptance.
  always_ff @(posedge CLK) begin
    acc_q    <= acc_d;
    rem_q    <= rem_d;
    opnd_q   <= opnd_d;
    a_raw_q  <= a_raw_d;
    negq_q   <= negq_d;
    negr_q   <= negr_d;
    zero_q   <= zero_d;
    is_div_q <= is_div_d;
  end

  assign busy          = busy_q;
  assign mult_div_done = done_q;
  assign hi_out        = hi_q;
  assign lo_out        = lo_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq with hand-computed results.
module tb_mult_div_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mult_start, div_start, signed_op;
  logic [31:0] op_a, op_b;
  logic        busy, mult_div_done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .mult_start(mult_start), .div_start(div_start),
    .signed_op(signed_op), .op_a(op_a), .op_b(op_b), .busy(busy),
    .mult_div_done(mult_div_done), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  // Drive a start for one cycle; returns 1ns after the accepting edge.
  task automatic do_start(input logic m, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    mult_start = m; div_start = d; signed_op = s; op_a = a; op_b = b;
    @(posedge CLK); #1;
    mult_start = 1'b0; div_start = 1'b0;
  endtask

  // Waits (bounded) for done; lat = -1 on timeout. busy_ok = busy held high before done.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK); #1;
      if (mult_div_done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; mult_start = 0; div_start = 0; signed_op = 0; op_a = 0; op_b = 0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mult_div_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", mult_div_done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
    RST = 1'b0;
  endtask

  task automatic test_mult_unsigned();
    int lat; bit bok;
    do_start(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mulu_busy_start got %b want 1", busy); end
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mulu_latency got %0d want 34", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL mulu_busy_held got 0 want 1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mulu_busy_at_done got %b want 0", busy); end
    checks++; if (hi_out !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_hi got %h want fffffffe", hi_out); end
    checks++; if (lo_out !== 32'h00000001) begin errors++; $display("FAIL mulu_lo got %h want 00000001", lo_out); end
    @(posedge CLK); #1;
    checks++; if (mult_div_done !== 1'b0) begin errors++; $display("FAIL mulu_done_pulse got %b want 0", mult_div_done); end
    checks++; if (lo_out !== 32'h00000001) begin errors++; $display("FAIL mulu_lo_hold got %h want 00000001", lo_out); end
  endtask

  task automatic test_mult_signed();
    int lat; bit bok;
    do_start(1, 0, 1, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL muls_latency got %0d want 34", lat); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL muls_hi got %h want ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFEB) begin errors++; $display("FAIL muls_lo got %h want ffffffeb", lo_out); end
    do_start(1, 0, 1, 32'h80000000, 32'h80000000);
    wait_done(lat, bok);
    checks++; if (hi_out !== 32'h40000000) begin errors++; $display("FAIL muls_min_hi got %h want 40000000", hi_out); end
    checks++; if (lo_out !== 32'h00000000) begin errors++; $display("FAIL muls_min_lo got %h want 00000000", lo_out); end
  endtask

  task automatic test_div();
    int lat; bit bok;
    do_start(0, 1, 1, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divs_latency got %0d want 34", lat); end
    checks++; if (lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL divs_quot got %h want fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL divs_rem got %h want ffffffff", hi_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divs_dbz got %b want 0", div_by_zero); end
    do_start(0, 1, 0, 32'd100, 32'd7);
    wait_done(lat, bok);
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL divu_quot got %h want 0000000e", lo_out); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL divu_rem got %h want 00000002", hi_out); end
    do_start(0, 1, 1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bok);
    checks++; if (lo_out !== 32'h80000000) begin errors++; $display("FAIL divs_min_quot got %h want 80000000", lo_out); end
    checks++; if (hi_out !== 32'h00000000) begin errors++; $display("FAIL divs_min_rem got %h want 00000000", hi_out); end
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    do_start(0, 1, 0, 32'h00001234, 32'h0);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL dz_latency got %0d want 34", lat); end
    checks++; if (lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_quot got %h want ffffffff", lo_out); end
    checks++; if (hi_out !== 32'h00001234) begin errors++; $display("FAIL dz_rem got %h want 00001234", hi_out); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    do_start(1, 0, 0, 32'd1, 32'd1);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
    wait_done(lat, bok);
    checks++; if (lo_out !== 32'd1) begin errors++; $display("FAIL dz_next_lo got %h want 00000001", lo_out); end
  endtask

  task automatic test_arbitration();
    int lat; bit bok;
    do_start(1, 1, 0, 32'd5, 32'd6);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL arb_latency got %0d want 34", lat); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL arb_hi got %h want 00000000", hi_out); end
    checks++; if (lo_out !== 32'd30) begin errors++; $display("FAIL arb_lo got %h want 0000001e", lo_out); end
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    int dones = 0;
    int disturbed = 0;
    do_start(0, 1, 0, 32'd100, 32'd7);
    for (int k = 1; k <= 60; k++) begin
      if (k == 9) begin div_start = 1'b1; op_a = 32'd9; op_b = 32'd3; end
      if (k == 10) div_start = 1'b0;
      @(posedge CLK); #1;
      if (mult_div_done) begin
        dones++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && (hi_out !== 32'd0 || lo_out !== 32'd30)) disturbed++;
    end
    checks++; if (disturbed !== 0) begin errors++; $display("FAIL ign_hold got %0d want 0 disturbed cycles", disturbed); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", dones); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ign_latency got %0d want 34", lat); end
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL ign_quot got %h want 0000000e", lo_out); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL ign_rem got %h want 00000002", hi_out); end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok;
    int dones = 0;
    do_start(0, 1, 0, 32'd100, 32'd7);
    repeat (14) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h want 0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", lo_out); end
    for (int k = 0; k < 50; k++) begin
      @(posedge CLK); #1;
      if (mult_div_done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dones); end
    do_start(1, 0, 0, 32'd2, 32'd3);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL rmid_mul_latency got %0d want 34", lat); end
    checks++; if (lo_out !== 32'd6) begin errors++; $display("FAIL rmid_mul_lo got %h want 00000006", lo_out); end
  endtask

  initial begin
    test_reset();
    test_mult_unsigned();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_arbitration();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Iterative multiply/divide unit and its sequencer, owning the HI/LO result pair for mult, mul and div instructions.
- Accepts a one-cycle start pulse from the sequence controller, latches operands, and iterates one bit per cycle.
- Returns a one-cycle mult_div_done pulse that the controller's wait states poll.
- Sits beside the ALU; hi_out/lo_out feed the HI/LO registers and the MEMtoREG mux.

Parameters:
- WIDTH, 32, operand and result half-width in bits (HI and LO are each WIDTH).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- mult_start  input  1  one-cycle request for a multiply.
- div_start  input  1  one-cycle request for a divide.
- signed_op  input  1  1 = signed operation, 0 = unsigned; sampled together with the start.
- op_a  input  WIDTH  multiplicand or dividend (rs); sampled with the start.
- op_b  input  WIDTH  multiplier or divisor (rt); sampled with the start.
- busy  output  1  high from the edge after an accepted start until mult_div_done is asserted.
- mult_div_done  output  1  one-cycle pulse; results are valid while it is high and afterwards.
- hi_out  output  WIDTH  product[2W-1:W] for multiply, remainder for divide.
- lo_out  output  WIDTH  product[W-1:0] for multiply, quotient for divide.
- div_by_zero  output  1  set with done when a divide had op_b==0; cleared at the next accepted start.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, counter=0, busy=0, mult_div_done=0, div_by_zero=0, hi_out=0, lo_out=0. This applies in any state; an in-flight operation is abandoned and no done is produced.
- Registered outputs only; no combinational path from inputs to outputs.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - A start sampled high at edge E0 is accepted.
  - Latch |op_a| and |op_b| when signed_op=1, raw values when signed_op=0.
  - Latch neg_q = a_sign^b_sign and neg_r = a_sign (both forced to 0 for unsigned).
  - Latch the zero-divisor flag; clear div_by_zero; counter=0.
  - Go to MUL for mult_start, DIV for div_start.
- Both starts high simultaneously: multiply wins and div_start is ignored.
- Starts while busy (any state other than IDLE): ignored, with no effect on the operation in flight.
- MUL: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator. WIDTH cycles; leave at counter==WIDTH-1.
- DIV: restoring division, one quotient bit per cycle, MSB first, WIDTH+1-bit partial remainder. WIDTH cycles.
- FIX (1 cycle):
  - Multiply: negate the full 2*WIDTH product if neg_q.
  - Divide: negate the quotient if neg_q and the remainder if neg_r.
  - Divisor zero: force quotient = all ones and remainder = original op_a (un-normalised), regardless of sign.
- DONE (1 cycle):
  - hi_out/lo_out are loaded and mult_div_done=1, div_by_zero updated; busy drops at this edge.
  - Next state is IDLE. A start in the DONE cycle is ignored; it must arrive in IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH+2, i.e. WIDTH+2 cycles after acceptance, fixed for all operand values.
- hi_out/lo_out hold their values until the DONE of the next operation or reset; they are not disturbed during iteration.
- Arithmetic edge cases:
  - Signed -2^(W-1) / -1 gives quotient 0x80000000 and remainder 0 (unsigned magnitude arithmetic, no trap).
  - Signed -2^(W-1) * -2^(W-1) gives 0x40000000_00000000.
  - Remainder sign always follows the dividend; |remainder| < |divisor|.

Test Plan:
- Unsigned mult: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, signed_op=0 -> after 34 cycles done pulse for 1 cycle, hi=0xFFFFFFFE, lo=0x00000001, busy low the same cycle.
- Signed mult: op_a=-3 (0xFFFFFFFD), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also check op_a=op_b=0x80000000 signed -> hi=0x40000000, lo=0.
- Signed div: op_a=-7, op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Unsigned 100/7 -> lo=14, hi=2. Also check 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Divide by zero: op_a=0x1234, op_b=0, div_start -> done at 34 cycles, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; next accepted start clears div_by_zero.
- Arbitration/busy:
  - mult_start and div_start high together (5*6) -> multiply result hi=0, lo=30.
  - A div_start pulse at cycle 10 of a busy operation -> ignored, hi/lo unchanged until the original done, and exactly one done pulse.
- Reset mid-operation: RST=1 at cycle 15 of a divide -> next cycle busy=0, hi/lo=0, and no done pulse ever appears. A new mult 2*3 issued afterwards -> lo=6 after 34 cycles.
